// File: rtl/interval_timer_pkg.sv
// Shared definitions for the interval timer: bus port indices, FSM states,
// CONTROL bit positions and the byte-lane write merge used by the bus peripherals.
package common;

   typedef enum logic [3:0] {
      PORT_CONTROL  = 4'd0,
      PORT_PRESCALE = 4'd1,
      PORT_COUNT    = 4'd2,
      PORT_COMPARE  = 4'd3,
      PORT_STATUS   = 4'd4
   } timer_port_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      EXPIRED = 2'd2
   } timer_state_t;

   localparam int CTRL_ENABLE   = 0;
   localparam int CTRL_PERIODIC = 1;
   localparam int CTRL_IRQ_EN   = 2;

   function automatic logic [31:0] apply_mask(input logic [31:0] cur,
                                              input logic [31:0] data,
                                              input logic [3:0]  mask);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = mask[b] ? data[8*b +: 8] : cur[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the interval timer: emits a one-cycle tick every divisor+1
// cycles while running; a divisor lowered below the count wraps through 16'hFFFF.
module timer_prescaler (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        clear,
   input  logic        run,
   input  logic [15:0] divisor,
   output logic        tick
);

   logic [15:0] cnt;

   assign tick = run & (cnt == divisor);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt <= 16'd0;
      end else if (clear) begin
         cnt <= 16'd0;
      end else if (run) begin
         cnt <= tick ? 16'd0 : cnt + 16'd1;
      end
   end

endmodule

// File: rtl/interval_timer.sv
// Memory-mapped 32-bit interval timer with sticky match flag and level interrupt.
// state   | meaning
// IDLE    | enable=0, prescaler held at 0, COUNT holds
// RUNNING | prescaler ticking, COUNT advances on each tick
// EXPIRED | one-shot matched, COUNT frozen until CONTROL.enable is rewritten
module interval_timer
   import common::*;
#(
   parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
   input  logic        clk_i,
   input  logic        reset_i,
   output logic        irq_o,
   input  logic        chip_select_i,
   input  logic [3:0]  addr_i,
   input  logic        read_enable_i,
   output logic [31:0] read_data_o,
   input  logic [31:0] write_data_i,
   input  logic [3:0]  write_mask_i
);

   timer_state_t state, state_nxt;
   logic        ctrl_en, ctrl_per, ctrl_irq;
   logic [15:0] prescale;
   logic [31:0] count, compare, rd_mux;
   logic        match_r;
   logic        wr, ctrl_b0, en_nxt, en_rise, running, tick, hit, expire, w1c;

   assign wr      = chip_select_i & (|write_mask_i);
   assign ctrl_b0 = wr & (addr_i == PORT_CONTROL) & write_mask_i[0];
   assign en_nxt  = ctrl_b0 ? write_data_i[CTRL_ENABLE] : ctrl_en;
   assign en_rise = ctrl_b0 & write_data_i[CTRL_ENABLE] & ~ctrl_en;
   assign running = (state == RUNNING);
   assign hit     = running & tick & (count == compare);
   assign expire  = hit & ~ctrl_per;
   assign w1c     = wr & (addr_i == PORT_STATUS) & write_mask_i[0] & write_data_i[0];
   assign irq_o   = match_r & ctrl_irq;

   timer_prescaler u_prescaler (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear   (~running | en_rise),
      .run     (running),
      .divisor (prescale),
      .tick    (tick)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en_nxt) state_nxt = RUNNING;
         RUNNING: begin
            if (expire)       state_nxt = EXPIRED;
            else if (!en_nxt) state_nxt = IDLE;
         end
         EXPIRED: if (ctrl_b0) state_nxt = write_data_i[CTRL_ENABLE] ? RUNNING : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rd_mux = 32'd0;
      case (addr_i)
         PORT_CONTROL:  rd_mux = {29'd0, ctrl_irq, ctrl_per, ctrl_en};
         PORT_PRESCALE: rd_mux = {16'd0, prescale};
         PORT_COUNT:    rd_mux = count;
         PORT_COMPARE:  rd_mux = compare;
         PORT_STATUS:   rd_mux = {29'd0, state, match_r};
         default:       rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) state <= IDLE;
      else         state <= state_nxt;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ctrl_en     <= 1'b0;
         ctrl_per    <= 1'b0;
         ctrl_irq    <= 1'b0;
         prescale    <= 16'd0;
         count       <= 32'd0;
         compare     <= RESET_COMPARE;
         match_r     <= 1'b0;
         read_data_o <= 32'd0;
      end else begin
         if (ctrl_b0) begin
            ctrl_en  <= write_data_i[CTRL_ENABLE];
            ctrl_per <= write_data_i[CTRL_PERIODIC];
            ctrl_irq <= write_data_i[CTRL_IRQ_EN];
         end
         // A one-shot expiry always drops enable, even against a same-cycle write.
         if (expire) ctrl_en <= 1'b0;
         if (wr && addr_i == PORT_PRESCALE) begin
            if (write_mask_i[0]) prescale[7:0]  <= write_data_i[7:0];
            if (write_mask_i[1]) prescale[15:8] <= write_data_i[15:8];
         end
         // Bus write beats the tick's increment/reload; match still sees the old COUNT.
         if (wr && addr_i == PORT_COUNT) begin
            count <= apply_mask(count, write_data_i, write_mask_i);
         end else if (running && tick) begin
            if (hit) count <= ctrl_per ? 32'd0 : count;
            else     count <= count + 32'd1;
         end
         if (wr && addr_i == PORT_COMPARE) begin
            compare <= apply_mask(compare, write_data_i, write_mask_i);
         end
         match_r <= hit | (match_r & ~w1c);
         if (chip_select_i && read_enable_i) read_data_o <= rd_mux;
      end
   end

endmodule
